beam_power_acc: RTL and testbench

BEAM_POWER_ACC -- requirements
Module: beam_power_acc

---
 rtl/beam_power_acc_if.sv | 18 +
 rtl/beam_power_acc.sv | 91 +++++++++
 tb/tb_beam_power_acc.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/beam_power_acc_if.sv
// beam_power_acc_if: RE stream in, accumulated beam power out
// i_data/i_rvalid/i_sop: RE stream toward the accumulator
// o_data/o_tvalid/o_tready/o_err: window results and status back
interface beam_power_acc_if #(
  parameter int IW  = 16,
  parameter int COL = 64,
  parameter int OW  = 32
);
  logic [COL-1:0][2*IW-1:0] i_data;
  logic                     i_rvalid;
  logic                     i_sop;
  logic [COL-1:0][OW-1:0]   o_data;
  logic                     o_tvalid;
  logic                     o_tready;
  logic                     o_err;
  modport master (output i_data, i_rvalid, i_sop, input o_data, o_tvalid, o_tready, o_err);
  modport slave  (input i_data, i_rvalid, i_sop, output o_data, o_tvalid, o_tready, o_err);
endinterface

// File: rtl/beam_power_acc.sv
// beam_power_acc: per-beam saturating I^2+Q^2 accumulation over ACC_LEN-RE windows
// i_clk: clock; i_reset: async active-low reset
// bus (slave): i_data {I,Q} per beam, i_rvalid, i_sop in; o_data, o_tvalid, o_tready, o_err out
module beam_power_acc #(
  parameter int IW      = 16,
  parameter int COL     = 64,
  parameter int OW      = 32,
  parameter int ACC_LEN = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  beam_power_acc_if.slave  bus
);
  localparam int DW = 2*IW;
  localparam int PW = 2*IW+1;
  localparam int SW = (OW > PW ? OW : PW) + 1;
  typedef enum logic {IDLE, ACC} state_t;
  logic [1:0]               rs_q;
  logic                     v0_q, s0_q, v1_q, s1_q, v2_q, s2_q;
  logic [COL-1:0][DW-1:0]   d0_q, ii_q, qq_q;
  logic [COL-1:0][PW-1:0]   p_q;
  logic [COL-1:0][OW-1:0]   acc_q, acc_d;
  logic [7:0]               cnt_q, cnt_d;
  state_t                   state_q, state_d;
  logic                     load, add, done_d, err_d, done_q, err_q;
  // Release synchronizer: input accepted from the second edge after deassertion
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) rs_q <= '0;
    else rs_q <= {rs_q[0], 1'b1};
  assign bus.o_tready = rs_q[1];
  // Input register, squares, then power sum; valid/sop ride alongside
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      {v0_q, s0_q, v1_q, s1_q, v2_q, s2_q} <= '0;
      d0_q <= '0;
      ii_q <= '0;
      qq_q <= '0;
      p_q  <= '0;
    end else begin
      v0_q <= bus.i_rvalid & rs_q[0];
      s0_q <= bus.i_sop;
      d0_q <= bus.i_data;
      v1_q <= v0_q;
      s1_q <= s0_q;
      v2_q <= v1_q;
      s2_q <= s1_q;
      for (int c = 0; c < COL; c++) begin
        ii_q[c] <= DW'($signed(d0_q[c][DW-1:IW]) * $signed(d0_q[c][DW-1:IW]));
        qq_q[c] <= DW'($signed(d0_q[c][IW-1:0]) * $signed(d0_q[c][IW-1:0]));
        p_q[c]  <= PW'(ii_q[c]) + PW'(qq_q[c]);
      end
    end
  // A sop RE always restarts the window; inside ACC that abandons the partial one
  always_comb begin
    load   = v2_q & s2_q;
    add    = v2_q & ~s2_q & (state_q == ACC);
    err_d  = load & (state_q == ACC);
    cnt_d  = load ? 8'd1 : cnt_q + 8'd1;
    done_d = (load | add) & (cnt_d == 8'(ACC_LEN));
  end
  always_comb state_d = done_d ? IDLE : (load | add) ? ACC : state_q;
  for (genvar c = 0; c < COL; c++) begin : g_acc
    logic [SW-1:0] s;
    assign s        = SW'(load ? {OW{1'b0}} : acc_q[c]) + SW'(p_q[c]);
    assign acc_d[c] = |s[SW-1:OW] ? {OW{1'b1}} : s[OW-1:0];
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (load | add) ? (done_d ? 8'd0 : cnt_d) : cnt_q;
      acc_q   <= (load | add) ? acc_d : acc_q;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      bus.o_data   <= '0;
      bus.o_tvalid <= 1'b0;
      bus.o_err    <= 1'b0;
    end else begin
      if (done_q) bus.o_data <= acc_q;
      bus.o_tvalid <= done_q;
      bus.o_err    <= err_q;
    end
endmodule

// File: tb/tb_beam_power_acc.sv
// tb_beam_power_acc: directed checks of window power, saturation, abort, gaps and reset
module tb_beam_power_acc;
  localparam int COL = 8;
  logic clk, rst_n, rvalid, sop;
  logic [COL-1:0][31:0] data;
  int checks = 0, errors = 0;
  int tv4 = 0, tv3 = 0, tv1 = 0, er4 = 0, er1 = 0;
  int t4, t3, t1, e4, e1, n;
  beam_power_acc_if #(.IW(16), .COL(COL), .OW(32)) b4 ();
  beam_power_acc_if #(.IW(16), .COL(COL), .OW(32)) b3 ();
  beam_power_acc_if #(.IW(16), .COL(COL), .OW(32)) b1 ();
  assign b4.i_data = data;
  assign b4.i_rvalid = rvalid;
  assign b4.i_sop = sop;
  assign b3.i_data = data;
  assign b3.i_rvalid = rvalid;
  assign b3.i_sop = sop;
  assign b1.i_data = data;
  assign b1.i_rvalid = rvalid;
  assign b1.i_sop = sop;
  beam_power_acc #(.IW(16), .COL(COL), .OW(32), .ACC_LEN(4)) u4 (.i_clk(clk), .i_reset(rst_n), .bus(b4));
  beam_power_acc #(.IW(16), .COL(COL), .OW(32), .ACC_LEN(3)) u3 (.i_clk(clk), .i_reset(rst_n), .bus(b3));
  beam_power_acc #(.IW(16), .COL(COL), .OW(32), .ACC_LEN(1)) u1 (.i_clk(clk), .i_reset(rst_n), .bus(b1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (b4.o_tvalid) tv4 <= tv4 + 1;
    if (b3.o_tvalid) tv3 <= tv3 + 1;
    if (b1.o_tvalid) tv1 <= tv1 + 1;
    if (b4.o_err) er4 <= er4 + 1;
    if (b1.o_err) er1 <= er1 + 1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [COL-1:0][31:0] one(input int b, input int i, input int q);
    logic [COL-1:0][31:0] v = '0;
    v[b] = {16'(i), 16'(q)};
    return v;
  endfunction
  function automatic logic [COL-1:0][31:0] all(input int i, input int q);
    logic [COL-1:0][31:0] v;
    for (int b = 0; b < COL; b++) v[b] = {16'(i), 16'(q)};
    return v;
  endfunction
  task automatic re(input logic s, input logic [COL-1:0][31:0] d);
    sop = s;
    data = d;
    rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    sop = 1'b0;
  endtask
  task automatic wait_tv(input int w, output int k);
    k = 0;
    while (!(w == 3 ? b3.o_tvalid : b4.o_tvalid) && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    rvalid = 1'b0;
    sop = 1'b0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", b4.o_tvalid, 0);
    chk("rst_tready", b4.o_tready, 0);
    chk("rst_data", |b4.o_data, 0);
    t4 = tv4; e4 = er4; t1 = tv1;
    rst_n = 1'b1;
    sop = 1'b1;
    rvalid = 1'b1;
    data = one(0, 10, 0);
    @(negedge clk);
    rvalid = 1'b0;
    sop = 1'b0;
    chk("tready_edge1", b4.o_tready, 0);
    re(1'b1, one(0, 3, 4));
    chk("tready_edge2", b4.o_tready, 1);
    repeat (3) re(1'b0, one(0, 3, 4));
    wait_tv(4, n);
    chk("w1_latency", n, 4);
    chk("w1_beam0", b4.o_data[0], 100);
    chk("w1_others", |b4.o_data[7:1], 0);
    @(negedge clk);
    chk("tvalid_width", b4.o_tvalid, 0);
    chk("w1_count", tv4 - t4, 1);
    chk("w1_err", er4 - e4, 0);
    chk("len1_beam0", b1.o_data[0], 25);
    chk("len1_count", tv1 - t1, 1);
    t4 = tv4;
    re(1'b1, all(-32768, -32768));
    repeat (3) re(1'b0, all(-32768, -32768));
    wait_tv(4, n);
    chk("sat_all", &b4.o_data, 1);
    chk("sat_beam3", b4.o_data[3], 32'hffff_ffff);
    repeat (2) @(negedge clk);
    chk("sat_count", tv4 - t4, 1);
    chk("len1_p_max", b1.o_data[2], 32'h8000_0000);
    t4 = tv4; e4 = er4; t1 = tv1; e1 = er1;
    re(1'b1, one(5, 7, 7));
    repeat (2) re(1'b0, one(5, 7, 7));
    re(1'b1, one(5, 1, 0));
    repeat (3) re(1'b0, one(5, 1, 0));
    wait_tv(4, n);
    chk("abort_latency", n, 4);
    chk("abort_beam5", b4.o_data[5], 4);
    repeat (3) @(negedge clk);
    chk("abort_count", tv4 - t4, 1);
    chk("abort_err", er4 - e4, 1);
    chk("len1_sops", tv1 - t1, 2);
    chk("len1_err", er1 - e1, 0);
    t4 = tv4;
    re(1'b1, one(0, 1, 1));
    re(1'b0, one(0, 1, 1));
    @(negedge clk);
    re(1'b0, one(0, 1, 1));
    repeat (5) @(negedge clk);
    chk("gap_early", tv4 - t4, 0);
    re(1'b0, one(0, 1, 1));
    wait_tv(4, n);
    chk("gap_latency", n, 4);
    chk("gap_beam0", b4.o_data[0], 8);
    t3 = tv3;
    re(1'b1, one(1, 2, 0));
    repeat (2) re(1'b0, one(1, 2, 0));
    re(1'b1, one(1, 0, 5));
    repeat (2) re(1'b0, one(1, 0, 5));
    wait_tv(3, n);
    chk("b2b_lat1", n, 1);
    chk("b2b_w1", b3.o_data[1], 12);
    @(negedge clk);
    wait_tv(3, n);
    chk("b2b_lat2", n, 2);
    chk("b2b_w2", b3.o_data[1], 75);
    repeat (2) @(negedge clk);
    chk("b2b_count", tv3 - t3, 2);
    t4 = tv4; e4 = er4;
    re(1'b1, one(0, 3, 4));
    re(1'b0, one(0, 3, 4));
    rst_n = 1'b0;
    #1;
    chk("rst_async_data", |b4.o_data, 0);
    chk("rst_async_tready", b4.o_tready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    re(1'b1, one(0, 3, 4));
    repeat (3) re(1'b0, one(0, 3, 4));
    wait_tv(4, n);
    chk("rst_w_latency", n, 4);
    chk("rst_w_beam0", b4.o_data[0], 100);
    repeat (2) @(negedge clk);
    chk("rst_w_count", tv4 - t4, 1);
    chk("rst_w_err", er4 - e4, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
